// File: rtl/shift_add_mult_pkg.sv
// ---------------------------------------------------------------------------
// Module : shift_add_mult_pkg
// Brief  : Shared FSM state type and default operand width for the
//          shift-and-add multiplier.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package shift_add_mult_pkg;

  // Default operand width in bits
  localparam int DEFAULT_WIDTH = 4;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// Module : shift_add_multiplier
// Brief  : Sequential unsigned WIDTH x WIDTH multiplier, one shift-and-add
//          iteration per clock, registered 2*WIDTH product and a one-cycle
//          done pulse.
// Config : SHIFT_ADD_MULT_EARLY_EXIT_EN - when defined, the calculation ends
//          as soon as the remaining multiplier bits are all zero.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module shift_add_multiplier
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,     // asynchronous, active-low
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   P,
  output logic                 done
);

  localparam int             CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t                 state;
  logic [2*WIDTH-1:0]     acc;
  logic [2*WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]       mplier;
  logic [CNT_W-1:0]       cnt;

  logic [2*WIDTH-1:0]     acc_next;
  logic                   last_iter;

  // Accumulator value produced by the current iteration (wraps mod 2^(2W))
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  // Current iteration is the final one: fixed count, or no multiplier bits left
  always_comb begin
    last_iter = (cnt == LAST_ITER);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    if ((mplier >> 1) == '0) begin
      last_iter = 1'b1;
    end
`endif
  end

  // Sequencer with datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      P      <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) begin
            P     <= acc_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // start is deliberately ignored here
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// Module : tb_shift_add_multiplier
// Brief  : Self-checking bench for shift_add_multiplier. Products and
//          latencies come from a behavioural model (a*b, bit length of b).
// Config : honours SHIFT_ADD_MULT_EARLY_EXIT_EN for expected latency.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shift_add_multiplier;

  localparam int W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic [2*W-1:0]   P;
  logic             done;

  int               n_vec = 0;
  int               n_err = 0;
  logic [2*W-1:0]   exp_p;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Expected cycles from start edge to the edge that raises done
  function automatic int exp_lat(input int b);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    int n;
    n = 0;
    while (b > 0) begin
      n++;
      b = b >> 1;
    end
    return (n == 0) ? 1 : n;
`else
    return W;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One operation; called and returns at posedge+1 with the DUT idle.
  // noise: 0 quiet, 1 start with A=2,B=2 during CALC, 2 random start/A/B.
  // sid: assert start during the DONE cycle and confirm it is ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int noise, input bit sid);
    logic [2*W-1:0] prod;
    int  lat;
    bit  seen;
    bit  held;
    bit  quiet;
    prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    lat   = 0;
    seen  = 1'b0;
    held  = 1'b1;
    start = 1'b1;
    A     = a;
    B     = b;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 3 * W && !seen; k++) begin
      if (noise == 1) begin
        start = 1'b1;
        A = W'(2);
        B = W'(2);
      end else if (noise == 2) begin
        start = 1'($urandom_range(0, 1));
        A = W'($urandom);
        B = W'($urandom);
      end else begin
        A = W'($urandom);
        B = W'($urandom);
      end
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        lat  = k;
      end else if (P !== exp_p) begin
        held = 1'b0;
      end
    end
    start = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    exp_p = prod;
    check("product", 64'(P), 64'(prod));
    check("latency", 64'(lat), 64'(exp_lat(int'(b))));
    check("p_hold", 64'(held), 64'd1);
    if (sid) begin
      start = 1'b1;
      A = W'(1);
      B = W'(1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", 64'(done), 64'd0);
    if (sid) begin
      quiet = 1'b1;
      repeat (W + 2) begin
        @(posedge clk); #1;
        if (done || P !== exp_p) quiet = 1'b0;
      end
      check("start_in_done_ignored", 64'(quiet), 64'd1);
    end
  endtask

  initial begin
    bit quiet;
    rst   = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    exp_p = '0;
    #12;
    check("reset_p", 64'(P), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(W'(6),  W'(3),  0, 1'b0);
    run_op(W'(15), W'(15), 0, 1'b0);
    run_op(W'(0),  W'(9),  0, 1'b0);
    run_op(W'(7),  W'(0),  0, 1'b1);
    run_op(W'(6),  W'(3),  1, 1'b0);

    // Asynchronous reset in the middle of 6*3
    start = 1'b1;
    A = W'(6);
    B = W'(3);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    exp_p = '0;
    check("async_reset_p", 64'(P), 64'd0);
    check("async_reset_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    quiet = 1'b1;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (done || P !== '0) quiet = 1'b0;
    end
    check("no_done_after_abort", 64'(quiet), 64'd1);
    run_op(W'(5), W'(5), 0, 1'b0);

    // Back-to-back: second start on the first IDLE edge
    run_op(W'(6), W'(3), 0, 1'b0);
    run_op(W'(9), W'(4), 0, 1'b0);

    // Randomized operations with noisy inputs during the calculation
    repeat (40) begin
      run_op(W'($urandom), W'($urandom), 2, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
